// File: rtl/coax_tx.sv
// coax_tx -- 3270 coax line transmitter.
//
// Serialises 10-bit words into Manchester bit cells. Each frame looks like this:
//   quiesce (five "1" cells), code violation (3 halves low, 3 halves high),
//   then per word: sync "1" cell, ten data cells (bit 9 first), parity cell,
//   then end sequence ("0" cell followed by one full bit time high).
// A word held when a parity cell ends is sent back-to-back with no new start
// sequence.
//
// Ports:
//   clk     system clock
//   reset   synchronous, active-high; returns the block to idle and drops any held word
//   data    10-bit word to transmit, sampled when load && ready
//   load    host request to hand over data
//   ready   holding register empty
//   tx      registered line level (idle 0)
//   active  registered driver enable, high for the whole frame
module coax_tx #(
  parameter int CLOCKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] data,
  input  logic       load,
  output logic       ready,
  output logic       tx,
  output logic       active
);

  localparam int HALF = CLOCKS_PER_BIT / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] CYC_ZERO = CW'(0);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_QUIESCE = 3'd1,
    ST_CV      = 3'd2,
    ST_SYNC    = 3'd3,
    ST_DATA    = 3'd4,
    ST_PARITY  = 3'd5,
    ST_END     = 3'd6
  } state_t;

  // state_r/half_r/cyc_r always describe the cycle currently shown on tx_r.
  state_t        state_r;
  logic [CW-1:0] cyc_r;
  logic [4:0]    half_r;
  logic [9:0]    shift_r;
  logic          parity_r;
  logic [9:0]    hold_r;
  logic          hold_full_r;
  logic          ready_r;
  logic          tx_r;
  logic          active_r;

  logic accept_s;
  logic xfer_s;
  logic last_half_s;
  logic next_bit_s;

  // Parity of a word including the implicit sync "1": even overall.
  function automatic logic frame_parity(input logic [9:0] w);
    return 1'b1 ^ (^w);
  endfunction

  // Index of the final half-cell of each active state.
  function automatic logic [4:0] last_half_of(input state_t st);
    case (st)
      ST_QUIESCE: return 5'd9;
      ST_CV:      return 5'd5;
      ST_SYNC:    return 5'd1;
      ST_DATA:    return 5'd19;
      ST_PARITY:  return 5'd1;
      ST_END:     return 5'd3;
      default:    return 5'd0;
    endcase
  endfunction

  // Line level for half h of state st; b is the cell value for data/parity cells.
  function automatic logic half_level(input state_t st, input logic [4:0] h, input logic b);
    case (st)
      ST_QUIESCE, ST_SYNC: return h[0];
      ST_CV:               return (h >= 5'd3);
      ST_DATA, ST_PARITY:  return h[0] ? b : ~b;
      ST_END:              return (h != 5'd1);
      default:             return 1'b0;
    endcase
  endfunction

  // Handshake qualifiers, end-of-state detect and the cell value of the upcoming half.
  always_comb begin
    accept_s    = load && ready_r;
    xfer_s      = (state_r == ST_SYNC) && (half_r == 5'd0) && (cyc_r == CYC_ZERO);
    last_half_s = (half_r == last_half_of(state_r));
    if (state_r == ST_PARITY) begin
      next_bit_s = parity_r;
    end else if (half_r[0]) begin
      // crossing into the next data cell: the shift happens on this same edge
      next_bit_s = shift_r[8];
    end else begin
      next_bit_s = shift_r[9];
    end
  end

  // Holding register and ready flag; an accept wins over a transfer in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_r      <= 10'd0;
      hold_full_r <= 1'b0;
      ready_r     <= 1'b1;
    end else if (accept_s) begin
      hold_r      <= data;
      hold_full_r <= 1'b1;
      ready_r     <= 1'b0;
    end else if (xfer_s) begin
      hold_full_r <= 1'b0;
      ready_r     <= 1'b1;
    end else begin
      hold_r      <= hold_r;
      hold_full_r <= hold_full_r;
      ready_r     <= ready_r;
    end
  end

  // Frame sequencer with registered tx/active, shift register and parity.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      cyc_r    <= CYC_ZERO;
      half_r   <= 5'd0;
      shift_r  <= 10'd0;
      parity_r <= 1'b0;
      tx_r     <= 1'b0;
      active_r <= 1'b0;
    end else begin
      if (xfer_s) begin
        shift_r  <= hold_r;
        parity_r <= frame_parity(hold_r);
      end else if ((state_r == ST_DATA) && (cyc_r == CYC_LAST) && half_r[0]) begin
        shift_r <= {shift_r[8:0], 1'b0};
      end

      case (state_r)
        ST_IDLE: begin
          if (hold_full_r) begin
            state_r  <= ST_QUIESCE;
            cyc_r    <= CYC_ZERO;
            half_r   <= 5'd0;
            tx_r     <= 1'b0;
            active_r <= 1'b1;
          end else begin
            tx_r     <= 1'b0;
            active_r <= 1'b0;
          end
        end
        default: begin
          if (cyc_r != CYC_LAST) begin
            cyc_r <= cyc_r + CW'(1);
          end else begin
            cyc_r <= CYC_ZERO;
            if (!last_half_s) begin
              half_r <= half_r + 5'd1;
              tx_r   <= half_level(state_r, half_r + 5'd1, next_bit_s);
            end else begin
              half_r <= 5'd0;
              case (state_r)
                ST_QUIESCE: begin
                  state_r <= ST_CV;
                  tx_r    <= 1'b0;
                end
                ST_CV: begin
                  state_r <= ST_SYNC;
                  tx_r    <= 1'b0;
                end
                ST_SYNC: begin
                  // shift_r was loaded on the first sync cycle
                  state_r <= ST_DATA;
                  tx_r    <= ~shift_r[9];
                end
                ST_DATA: begin
                  state_r <= ST_PARITY;
                  tx_r    <= ~parity_r;
                end
                ST_PARITY: begin
                  if (hold_full_r) begin
                    state_r <= ST_SYNC;
                    tx_r    <= 1'b0;
                  end else begin
                    state_r <= ST_END;
                    tx_r    <= 1'b1;
                  end
                end
                ST_END: begin
                  state_r  <= ST_IDLE;
                  tx_r     <= 1'b0;
                  active_r <= 1'b0;
                end
                default: begin
                  state_r  <= ST_IDLE;
                  tx_r     <= 1'b0;
                  active_r <= 1'b0;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

  assign ready  = ready_r;
  assign tx     = tx_r;
  assign active = active_r;

endmodule

// File: tb/tb_coax_tx.sv
// Self-checking bench for coax_tx. Every frame on the line is captured and
// compared against a waveform built from the frame rules (cells and halves
// pushed into a queue) for the words the bench saw accepted.
module tb_coax_tx;

  localparam int CPB  = 8;
  localparam int HALF = CPB / 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] data = 10'd0;
  logic       load = 1'b0;
  logic       ready;
  logic       tx;
  logic       active;

  coax_tx #(.CLOCKS_PER_BIT(CPB)) dut (
    .clk    (clk),
    .reset  (reset),
    .data   (data),
    .load   (load),
    .ready  (ready),
    .tx     (tx),
    .active (active)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  logic       cur_q[$];
  logic [9:0] acc_q[$];
  logic       exp_w[$];
  int         frames_done = 0;
  int         last_len = 0;
  int         last_n = 0;
  logic       last_par = 1'b0;
  int         idle_bad = 0;
  int         total_acc = 0;

  typedef struct {
    logic [9:0] word;
    logic       exp_par;
  } vec_t;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  function automatic void push_half(input logic lvl);
    for (int i = 0; i < HALF; i++) exp_w.push_back(lvl);
  endfunction

  function automatic void push_cell(input logic b);
    push_half(~b);
    push_half(b);
  endfunction

  // Reference waveform for a frame carrying the first n words of acc_q.
  function automatic void build_frame(input int n);
    logic [9:0] w;
    exp_w.delete();
    for (int i = 0; i < 5; i++) push_cell(1'b1);
    for (int i = 0; i < 3; i++) push_half(1'b0);
    for (int i = 0; i < 3; i++) push_half(1'b1);
    for (int k = 0; k < n; k++) begin
      w = acc_q[k];
      push_cell(1'b1);
      for (int b = 9; b >= 0; b--) push_cell(w[b]);
      push_cell(1'b1 ^ (^w));
    end
    push_cell(1'b0);
    push_half(1'b1);
    push_half(1'b1);
  endfunction

  task automatic check_frame();
    int len;
    int n;
    int mism;
    len = cur_q.size();
    n = (len / CPB - 10) / 12;
    if (n < 1) n = 1;
    check("frame_len", len, (10 + 12 * n) * CPB);
    check("frame_words_known", (acc_q.size() >= n) ? 1 : 0, 1);
    if (acc_q.size() >= n) begin
      build_frame(n);
      mism = 0;
      for (int i = 0; i < len; i++) begin
        if (i >= exp_w.size()) mism++;
        else if (cur_q[i] !== exp_w[i]) mism++;
      end
      if (exp_w.size() > len) mism += exp_w.size() - len;
      check("frame_wave", mism, 0);
      for (int k = 0; k < n; k++) void'(acc_q.pop_front());
    end
    last_len = len;
    last_n   = n;
    if (len > 157) last_par = cur_q[157];
    frames_done++;
  endtask

  // Line monitor: records accepts and frame samples away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      cur_q.delete();
      acc_q.delete();
    end else begin
      if (load && ready) begin
        acc_q.push_back(data);
        total_acc++;
      end
      if (active) begin
        cur_q.push_back(tx);
      end else begin
        if (tx !== 1'b0) idle_bad++;
        if (cur_q.size() > 0) begin
          check_frame();
          cur_q.delete();
        end
      end
    end
  end

  task automatic send(input logic [9:0] w);
    int got;
    got = 0;
    @(posedge clk); #1;
    load = 1'b1;
    data = w;
    for (int i = 0; i < 3000 && got == 0; i++) begin
      @(negedge clk);
      if (ready) got = 1;
    end
    @(posedge clk); #1;
    load = 1'b0;
    check("send_accepted", got, 1);
  endtask

  task automatic wait_frames(input int target);
    int k;
    k = 0;
    while (frames_done < target && k < 6000) begin
      @(negedge clk);
      k++;
    end
    check("frame_completed", (frames_done >= target) ? 1 : 0, 1);
  endtask

  task automatic wait_active();
    int k;
    k = 0;
    while (!active && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("active_seen", active ? 1 : 0, 1);
  endtask

  vec_t vecs[5];

  initial begin
    int t;
    int f0;
    int acc0;

    vecs[0] = '{10'h000, 1'b1};
    vecs[1] = '{10'h001, 1'b0};
    vecs[2] = '{10'h3FF, 1'b1};
    vecs[3] = '{10'h155, 1'b0};
    vecs[4] = '{10'h2AA, 1'b0};

    // reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_tx", tx, 0);
    check("reset_active", active, 0);
    check("reset_ready", ready, 1);

    // single word 2AA: latency and ready timing by hand
    @(posedge clk); #1;
    load = 1'b1;
    data = 10'h2AA;
    @(negedge clk);
    check("ready_at_load", ready, 1);
    @(posedge clk); #1;
    load = 1'b0;
    @(negedge clk);
    check("ready_after_accept", ready, 0);
    check("active_n_plus_1", active, 0);
    @(negedge clk);
    check("active_n_plus_2", active, 1);
    t = 0;
    while (!ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("ready_rise_cycle", t, 65);
    wait_frames(1);
    check("len_2aa", last_len, 176);
    check("par_2aa", last_par, 0);

    // table of single-word frames
    for (int v = 0; v < 5; v++) begin
      f0 = frames_done;
      send(vecs[v].word);
      wait_frames(f0 + 1);
      check($sformatf("len_%03h", vecs[v].word), last_len, 176);
      check($sformatf("par_%03h", vecs[v].word), last_par, vecs[v].exp_par);
      check($sformatf("idle_tx_%03h", vecs[v].word), tx, 0);
    end

    // back-to-back: second word arrives while the first is in its data cells
    f0 = frames_done;
    send(10'h155);
    wait_active();
    repeat (80) @(negedge clk);
    send(10'h0F0);
    wait_frames(f0 + 1);
    check("b2b_len", last_len, 272);
    check("b2b_words", last_n, 2);

    // reset in the middle of data bit 4, then a full frame afterwards
    send(10'h2AA);
    wait_active();
    repeat (106) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midreset_tx", tx, 0);
    check("midreset_active", active, 0);
    check("midreset_ready", ready, 1);
    f0 = frames_done;
    send(10'h3FF);
    wait_frames(f0 + 1);
    check("post_reset_len", last_len, 176);

    // word accepted during the end sequence starts its own frame
    f0 = frames_done;
    send(10'h0C3);
    wait_active();
    repeat (164) @(negedge clk);
    send(10'h21E);
    wait_frames(f0 + 2);
    check("end_load_len", last_len, 176);

    // load held high with changing data: only words seen with ready=1 go out
    f0 = frames_done;
    acc0 = total_acc;
    @(posedge clk); #1;
    load = 1'b1;
    for (int i = 0; i < 700; i++) begin
      data = 10'($urandom_range(0, 1023));
      @(posedge clk); #1;
    end
    load = 1'b0;
    wait_frames(f0 + 1);
    check("held_load_enough_words", (total_acc - acc0 >= 6) ? 1 : 0, 1);
    check("held_load_all_sent", acc_q.size(), 0);

    // random words with random gaps
    for (int i = 0; i < 6; i++) begin
      send(10'($urandom_range(0, 1023)));
      repeat ($urandom_range(0, 200)) @(negedge clk);
    end
    t = 0;
    while ((acc_q.size() != 0 || active || cur_q.size() != 0) && t < 8000) begin
      @(negedge clk);
      t++;
    end
    check("random_drained", acc_q.size(), 0);
    check("random_line_idle", active, 0);
    check("idle_tx_low", idle_bad, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
